// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction
// over a req/ack port and presents it to the decoder until it is consumed.
module instr_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   output logic [5:0]  opcode,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;

   logic [31:0] pc4;
   logic [31:0] off_sh;
   logic [31:0] next_pc;

   // Jump outranks a simultaneous taken branch.
   always_comb begin
      pc4    = instr_pc_q + 32'd4;
      off_sh = branch_offset << 2;
      if (jump)
         next_pc = {pc4[31:28], jump_target, 2'b00};
      else if (branch_taken)
         next_pc = pc4 + off_sh;
      else
         next_pc = pc4;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      count_d    = count_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               instr_d    = imem_rdata;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!stall) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               count_d = count_q + 32'd1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= PC_RESET;
         instr_q    <= 32'd0;
         instr_pc_q <= 32'd0;
         valid_q    <= 1'b0;
         count_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         count_q    <= count_d;
      end
   end

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign opcode      = valid_q ? instr_q[31:26] : 6'b111111;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed vector table, reset corner cases and
// randomized traffic against a transaction-level PC model.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_target;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic [5:0]  opcode;
   logic [31:0] fetch_count;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   instr_fetch #(.PC_RESET(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .opcode(opcode), .fetch_count(fetch_count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      logic        br;
      logic [31:0] off;
      logic        jmp;
      logic [25:0] tgt;
      logic [31:0] nxt;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] pc,
      input logic br, input logic [31:0] off,
      input logic jmp, input logic [25:0] tgt);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      if (jmp) return (p4 & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
      if (br)  return p4 + off * 32'd4;
      return p4;
   endfunction

   // Wait `w` cycles with a pending request, then ack with rdata.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] d,
                           input int w);
      for (int k = 0; k < w; k++) begin
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, a);
         tick();
      end
      chk("req", {31'd0, imem_req}, 32'd1);
      chk("addr", imem_addr, a);
      chk("pre_valid", {31'd0, instr_valid}, 32'd0);
      imem_ack = 1'b1;
      imem_rdata = d;
      tick();
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, d);
      chk("instr_pc", instr_pc, a);
      chk("opcode", {26'd0, opcode}, {26'd0, d[31:26]});
      chk("hold_req", {31'd0, imem_req}, 32'd0);
   endtask

   // Stall for s cycles with stray acks and junk control, then consume.
   task automatic do_consume(input int s, input logic br,
      input logic [31:0] off, input logic jmp, input logic [25:0] tgt,
      input logic [31:0] a, input logic [31:0] d, input logic [31:0] nxt);
      stall = 1'b1;
      for (int k = 0; k < s; k++) begin
         imem_ack = 1'b1;
         imem_rdata = ~d;
         branch_taken = 1'($urandom);
         branch_offset = $urandom;
         jump = 1'($urandom);
         jump_target = 26'($urandom);
         tick();
         chk("stall_instr", instr, d);
         chk("stall_pc", instr_pc, a);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_cnt", fetch_count, m_cnt);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      imem_ack = 1'b0;
      stall = 1'b0;
      branch_taken = br;
      branch_offset = off;
      jump = jmp;
      jump_target = tgt;
      tick();
      m_cnt = m_cnt + 32'd1;
      branch_taken = 1'b0;
      jump = 1'b0;
      chk("next_addr", imem_addr, nxt);
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("cons_valid", {31'd0, instr_valid}, 32'd0);
      chk("cons_opcode", {26'd0, opcode}, 32'h3F);
      chk("count", fetch_count, m_cnt);
   endtask

   initial begin
      logic [31:0] mpc, d, off, nxt;
      logic        br, jmp;
      logic [25:0] tgt;

      vecs[0] = '{32'h0040_0000, 32'h2408_0005, 0, 32'h0, 0, 26'h0, 32'h0040_0004};
      vecs[1] = '{32'h0040_0004, 32'h0000_0000, 0, 32'h0, 0, 26'h0, 32'h0040_0008};
      vecs[2] = '{32'h0040_0008, 32'h1000_FFFE, 1, 32'hFFFF_FFFE, 0, 26'h0, 32'h0040_0004};
      vecs[3] = '{32'h0040_0004, 32'h1000_0002, 1, 32'h0000_0002, 0, 26'h0, 32'h0040_0010};
      vecs[4] = '{32'h0040_0010, 32'h0810_0010, 1, 32'h0000_0005, 1, 26'h010_0010, 32'h0040_0040};
      vecs[5] = '{32'h0040_0040, 32'h0BFF_FFFF, 0, 32'h0, 1, 26'h3FF_FFFF, 32'h0FFF_FFFC};
      vecs[6] = '{32'h0FFF_FFFC, 32'h8C08_0000, 0, 32'h0, 0, 26'h0, 32'h1000_0000};
      vecs[7] = '{32'h1000_0000, 32'h1000_0000, 1, 32'h3BFF_FFFE, 0, 26'h0, 32'hFFFF_FFFC};
      vecs[8] = '{32'hFFFF_FFFC, 32'hAC08_0004, 0, 32'h0, 0, 26'h0, 32'h0000_0000};

      rst_n = 1'b0;
      stall = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = 32'd0;
      branch_taken = 1'b0;
      branch_offset = 32'd0;
      jump = 1'b0;
      jump_target = 26'd0;
      m_cnt = 32'd0;
      tick();
      tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_instr", instr, 32'd0);
      chk("rst_ipc", instr_pc, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_opcode", {26'd0, opcode}, 32'h3F);
      chk("rst_cnt", fetch_count, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("t1_req", {31'd0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, RST_PC);
      chk("t1_opcode", {26'd0, opcode}, 32'h3F);

      for (int i = 0; i < 9; i++) begin
         do_fetch(vecs[i].pc, vecs[i].rdata, i % 3);
         do_consume((i == 1) ? 3 : i % 2, vecs[i].br, vecs[i].off,
                    vecs[i].jmp, vecs[i].tgt, vecs[i].pc,
                    vecs[i].rdata, vecs[i].nxt);
      end

      // Reset while a fetch is outstanding.
      tick();
      tick();
      chk("t6_wait_req", {31'd0, imem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_req", {31'd0, imem_req}, 32'd0);
      chk("t6_valid", {31'd0, instr_valid}, 32'd0);
      chk("t6_addr", imem_addr, RST_PC);
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      rst_n = 1'b1;
      tick();
      imem_ack = 1'b0;
      m_cnt = 32'd0;
      chk("t6_cnt", fetch_count, 32'd0);
      chk("t6_valid2", {31'd0, instr_valid}, 32'd0);
      chk("t6_req2", {31'd0, imem_req}, 32'd1);
      chk("t6_addr2", imem_addr, RST_PC);

      mpc = RST_PC;
      for (int i = 0; i < 200; i++) begin
         d   = $urandom;
         br  = 1'($urandom);
         off = 32'($urandom_range(0, 64)) - 32'd32;
         jmp = ($urandom_range(0, 3) == 0);
         tgt = 26'($urandom);
         nxt = ref_next(mpc, br, off, jmp, tgt);
         do_fetch(mpc, d, int'($urandom_range(0, 3)));
         do_consume(int'($urandom_range(0, 2)), br, off, jmp, tgt,
                    mpc, d, nxt);
         mpc = nxt;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
